mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive LSU wins allowed while fetch waits.
REQ-002 SHALL have parameter CNT_W, default 32, meaning the perf counter width.
REQ-003 SHALL have port i_clk, in, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_reset, in, 1, a synchronous active-high reset.
REQ-005 SHALL have ports i_if_req in 1, i_if_addr in 32, o_if_gnt out 1, o_if_rvalid out 1, o_if_rdata out 32, forming the instruction-fetch requester.
REQ-006 SHALL have ports i_ls_req in 1, i_ls_we in 1, i_ls_addr in 32, i_ls_wdata in 32, i_ls_bmask in 4, o_ls_gnt out 1, o_ls_rvalid out 1, o_ls_rdata out 32, forming the load/store requester.
REQ-007 SHALL have port i_flush, in, 1, a mispredict flush that kills any in-flight fetch.
REQ-008 SHALL have ports o_mem_req out 1, o_mem_we out 1, o_mem_addr out 32, o_mem_wdata out 32, o_mem_bmask out 4, i_mem_rvalid in 1, i_mem_rdata in 32, forming the single-port memory.
REQ-009 SHALL have ports o_perf_if_stall out CNT_W and o_perf_ls_xact out CNT_W as performance counters.

Function
REQ-010 SHALL use an FSM with states IDLE, BUSY_IF and BUSY_LS, allowing one outstanding memory transaction.
REQ-011 In IDLE with a winning request, SHALL assert o_mem_req and the winner's gnt combinationally in the same cycle, then enter the winner's BUSY state.
REQ-012 SHALL give LSU priority over fetch unless the starvation counter equals STARVE_MAX, in which case fetch wins.
REQ-013 Starvation counter: increments when LSU wins while i_if_req=1; clears on a fetch grant or when i_if_req=0; saturates at STARVE_MAX.
REQ-014 SHALL drive o_mem_addr as {addr[31:2],2'b00}; o_mem_we, o_mem_wdata and o_mem_bmask come from the LSU, and are 0 / 0 / 4'hF for fetch.
REQ-015 In BUSY, SHALL hold o_mem_req=0 and both gnt=0, and wait for i_mem_rvalid; a write also completes on i_mem_rvalid.
REQ-016 On i_mem_rvalid, SHALL pulse the owner's rvalid for 1 cycle with rdata=i_mem_rdata, then return to IDLE; the next grant comes no earlier than the following cycle (minimum 2 cycles per transaction).
REQ-017 o_if_rdata/o_ls_rdata SHALL hold their last delivered value when not valid.
REQ-018 i_flush in BUSY_IF, or in IDLE in the same cycle as a fetch grant, SHALL set a drop flag; the matching response still returns the FSM to IDLE but o_if_rvalid stays 0.
REQ-019 i_flush SHALL NOT affect an LSU transaction, and SHALL NOT block a fetch grant in the cycle after the flush.
REQ-020 i_mem_rvalid seen in IDLE (stray) SHALL be ignored.
REQ-021 Simultaneous i_if_req and i_ls_req SHALL produce exactly one gnt; the loser keeps its request asserted and is served later.

Reset
REQ-022 On i_reset, SHALL set the state to IDLE and clear the starvation counter, drop flag, all gnt/rvalid/o_mem_req, rdata and counters to 0, regardless of any in-flight transaction.
REQ-023 A response arriving after reset SHALL be treated as stray per REQ-020.

Configuration
REQ-024 With ARB_PERF_EN defined: o_perf_if_stall SHALL count cycles where i_if_req=1 and o_if_gnt=0, and o_perf_ls_xact SHALL count LSU grants, both wrapping at 2^CNT_W.
REQ-025 Without ARB_PERF_EN, both perf ports SHALL exist and be tied to 0, with no counter flops instantiated.

Structure
REQ-026 Package arb_pkg SHALL hold the arb_state_e enum (IDLE/BUSY_IF/BUSY_LS), the owner_e enum and the default STARVE_MAX.
REQ-027 Sub-module arb_perf_cnt (enable, synchronous clear, wrapping counter) SHALL be instantiated twice under ARB_PERF_EN.

Verification
REQ-028 Fetch only, addr 0x0000_0104, memory returns 0xDEAD_BEEF after 3 cycles -> o_mem_addr=0x104, gnt in cycle 0, o_if_rvalid with 0xDEADBEEF in cycle 3.
REQ-029 Both requesting continuously -> grant order LS,LS,LS,LS,IF repeating; o_perf_if_stall increments each waiting cycle.
REQ-030 LSU store, addr 0x2003, bmask 4'b0011 -> o_mem_addr=0x2000, o_mem_we=1, then o_ls_rvalid pulse on ack.
REQ-031 i_flush one cycle after a fetch grant -> no o_if_rvalid, FSM in IDLE after the response, next fetch granted normally.
REQ-032 i_reset during BUSY_LS, then a late i_mem_rvalid -> o_ls_rvalid stays 0, all outputs 0, state IDLE.
REQ-033 Build without ARB_PERF_EN and rerun REQ-029 -> both perf outputs constant 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for the fetch/LSU memory arbiter: FSM states, owner tags, request bundle.
package arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_IF = 2'd1, BUSY_LS = 2'd2} arb_state_e;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_LS = 2'd2} owner_e;

  localparam int DEF_STARVE_MAX = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
  } mem_req_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/arb_perf_cnt.sv
// Wrapping event counter with synchronous clear; used by mem_arbiter when ARB_PERF_EN is defined.
module arb_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (clr)     cnt <= '0;
    else if (en) cnt <= cnt + CNT_W'(1);
  end
endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and LSU, with fetch
// anti-starvation and flush-drop of in-flight fetches. Perf counters exist only with ARB_PERF_EN.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_if_req,
  input  logic [31:0]      i_if_addr,
  output logic             o_if_gnt,
  output logic             o_if_rvalid,
  output logic [31:0]      o_if_rdata,
  input  logic             i_ls_req,
  input  logic             i_ls_we,
  input  logic [31:0]      i_ls_addr,
  input  logic [31:0]      i_ls_wdata,
  input  logic [3:0]       i_ls_bmask,
  output logic             o_ls_gnt,
  output logic             o_ls_rvalid,
  output logic [31:0]      o_ls_rdata,
  input  logic             i_flush,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic [31:0]      o_mem_addr,
  output logic [31:0]      o_mem_wdata,
  output logic [3:0]       o_mem_bmask,
  input  logic             i_mem_rvalid,
  input  logic [31:0]      i_mem_rdata,
  output logic [CNT_W-1:0] o_perf_if_stall,
  output logic [CNT_W-1:0] o_perf_ls_xact
);
  localparam int SW = $clog2(STARVE_MAX + 2);

  arb_state_e  state;
  owner_e      win;
  mem_req_t    mreq;
  logic [SW-1:0] starve;
  logic        drop;
  logic [31:0] if_rdata_q, ls_rdata_q;

  // Fetch overrides LSU priority only once it has lost STARVE_MAX times in a row.
  always_comb begin
    win = OWN_NONE;
    if (!i_reset && state == IDLE) begin
      if (i_ls_req && !(i_if_req && starve == SW'(STARVE_MAX))) win = OWN_LS;
      else if (i_if_req)                                        win = OWN_IF;
    end
  end

  always_comb begin
    mreq = '0;
    case (win)
      OWN_IF: begin
        mreq.addr  = word_align(i_if_addr);
        mreq.bmask = 4'hF;
      end
      OWN_LS: begin
        mreq.we    = i_ls_we;
        mreq.addr  = word_align(i_ls_addr);
        mreq.wdata = i_ls_wdata;
        mreq.bmask = i_ls_bmask;
      end
      default: ;
    endcase
  end

  assign o_if_gnt    = (win == OWN_IF);
  assign o_ls_gnt    = (win == OWN_LS);
  assign o_mem_req   = (win != OWN_NONE);
  assign o_mem_we    = mreq.we;
  assign o_mem_addr  = mreq.addr;
  assign o_mem_wdata = mreq.wdata;
  assign o_mem_bmask = mreq.bmask;

  // A flush coinciding with the response still kills it.
  assign o_if_rvalid = !i_reset && state == BUSY_IF && i_mem_rvalid && !drop && !i_flush;
  assign o_ls_rvalid = !i_reset && state == BUSY_LS && i_mem_rvalid;
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : if_rdata_q;
  assign o_ls_rdata  = o_ls_rvalid ? i_mem_rdata : ls_rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      starve     <= '0;
      drop       <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      if (o_if_rvalid) if_rdata_q <= i_mem_rdata;
      if (o_ls_rvalid) ls_rdata_q <= i_mem_rdata;
      if (win == OWN_IF || !i_if_req)                      starve <= '0;
      else if (win == OWN_LS && starve != SW'(STARVE_MAX)) starve <= starve + SW'(1);
      case (state)
        IDLE: begin
          if (win == OWN_IF) begin
            state <= BUSY_IF;
            drop  <= i_flush;
          end else if (win == OWN_LS) begin
            state <= BUSY_LS;
          end
        end
        BUSY_IF: begin
          if (i_mem_rvalid) begin
            state <= IDLE;
            drop  <= 1'b0;
          end else if (i_flush) begin
            drop  <= 1'b1;
          end
        end
        BUSY_LS: if (i_mem_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_EN
  arb_perf_cnt #(.CNT_W(CNT_W)) u_if_stall (
    .clk(i_clk), .clr(i_reset), .en(i_if_req && !o_if_gnt), .cnt(o_perf_if_stall)
  );
  arb_perf_cnt #(.CNT_W(CNT_W)) u_ls_xact (
    .clk(i_clk), .clr(i_reset), .en(o_ls_gnt), .cnt(o_perf_ls_xact)
  );
`else
  assign o_perf_if_stall = '0;
  assign o_perf_ls_xact  = '0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + randomized bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int SM = 4;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst;
  logic if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [3:0] ls_bmask;
  logic flush;
  logic mem_req, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_bmask;
  logic [CW-1:0] perf_stall, perf_lsx;

  int checks = 0, passed = 0;

  // reference model: owner 0 none / 1 fetch / 2 lsu
  int own, starve, last_win, lat;
  bit drop;
  logic [31:0] m_if_rd, m_ls_rd;
  logic [CW-1:0] m_stall, m_lsx;
  int grants[$];

  logic s_if_gnt, s_ls_gnt, s_mem_req, s_mem_we, s_if_rv, s_ls_rv;
  logic [31:0] s_mem_addr, s_if_rd, s_ls_rd;
  logic [CW-1:0] s_p0, s_p1;

  mem_arbiter #(.STARVE_MAX(SM), .CNT_W(CW)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
    .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
    .i_ls_bmask(ls_bmask), .o_ls_gnt(ls_gnt), .o_ls_rvalid(ls_rvalid), .o_ls_rdata(ls_rdata),
    .i_flush(flush),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_bmask(mem_bmask), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_perf_if_stall(perf_stall), .o_perf_ls_xact(perf_lsx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Inputs are already driven (posedge+1); check mid-cycle, then advance the model one clock.
  task automatic cyc();
    int win;
    bit ev_if, ev_ls;
    #4;
    win = 0;
    if (!rst && own == 0) begin
      if (if_req && ls_req) win = (starve == SM) ? 1 : 2;
      else if (ls_req)      win = 2;
      else if (if_req)      win = 1;
    end
    ev_if = !rst && own == 1 && mem_rvalid && !drop && !flush;
    ev_ls = !rst && own == 2 && mem_rvalid;
    chk("if_gnt", if_gnt, win == 1);
    chk("ls_gnt", ls_gnt, win == 2);
    chk("mem_req", mem_req, win != 0);
    if (win == 1) begin
      chk("if_addr", mem_addr, {if_addr[31:2], 2'b00});
      chk("if_we", mem_we, 0);
      chk("if_wdata", mem_wdata, 0);
      chk("if_bmask", mem_bmask, 4'hF);
    end
    if (win == 2) begin
      chk("ls_addr", mem_addr, {ls_addr[31:2], 2'b00});
      chk("ls_we", mem_we, ls_we);
      chk("ls_wdata", mem_wdata, ls_wdata);
      chk("ls_bmask", mem_bmask, ls_bmask);
    end
    chk("if_rvalid", if_rvalid, ev_if);
    chk("ls_rvalid", ls_rvalid, ev_ls);
    if (ev_if) m_if_rd = mem_rdata;
    if (ev_ls) m_ls_rd = mem_rdata;
    chk("if_rdata", if_rdata, m_if_rd);
    chk("ls_rdata", ls_rdata, m_ls_rd);
`ifdef ARB_PERF_EN
    chk("perf_stall", perf_stall, m_stall);
    chk("perf_lsx", perf_lsx, m_lsx);
`else
    chk("perf_stall0", perf_stall, 0);
    chk("perf_lsx0", perf_lsx, 0);
`endif
    {s_if_gnt, s_ls_gnt, s_mem_req, s_mem_we, s_if_rv, s_ls_rv} =
      {if_gnt, ls_gnt, mem_req, mem_we, if_rvalid, ls_rvalid};
    {s_mem_addr, s_if_rd, s_ls_rd, s_p0, s_p1} = {mem_addr, if_rdata, ls_rdata, perf_stall, perf_lsx};
    last_win = win;
    if (rst) begin
      own = 0; starve = 0; drop = 0;
      m_if_rd = '0; m_ls_rd = '0; m_stall = '0; m_lsx = '0;
    end else begin
      if (if_req && win != 1) m_stall++;
      if (win == 2) m_lsx++;
      if (win == 1 || !if_req)          starve = 0;
      else if (win == 2 && starve < SM) starve++;
      if (win != 0) begin
        own = win; drop = (win == 1) && flush; lat = $urandom_range(0, 2);
        grants.push_back(win);
      end else if (own != 0 && mem_rvalid) begin
        own = 0; drop = 0;
      end else if (own == 1 && flush) begin
        drop = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int pat[10];
    pat = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
    {if_req, ls_req, ls_we, flush, mem_rvalid} = '0;
    {if_addr, ls_addr, ls_wdata, mem_rdata} = '0;
    ls_bmask = '0;
    own = 0; starve = 0; drop = 0; last_win = 0; lat = 0;
    m_if_rd = '0; m_ls_rd = '0; m_stall = '0; m_lsx = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("rst_gnt", {s_if_gnt, s_ls_gnt, s_mem_req}, 0);
    chk("rst_rdata", {s_if_rd, s_ls_rd}, 0);
    chk("rst_perf", {s_p0, s_p1}, 0);

    // fetch only, 3-cycle memory latency
    if_req = 1; if_addr = 32'h0000_0104;
    cyc();
    chk("f_gnt", s_if_gnt, 1);
    chk("f_addr", s_mem_addr, 32'h104);
    if_req = 0;
    cyc(); cyc();
    mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    cyc();
    chk("f_rvalid", s_if_rv, 1);
    chk("f_rdata", s_if_rd, 32'hDEAD_BEEF);
    mem_rvalid = 0; mem_rdata = 32'h0;
    cyc();
    chk("f_hold_v", s_if_rv, 0);
    chk("f_hold_d", s_if_rd, 32'hDEAD_BEEF);

    // both requesting continuously: LS x4 then IF
    rst = 1; cyc(); rst = 0;
    grants.delete();
    if_req = 1; ls_req = 1; if_addr = 32'h80; ls_addr = 32'h44; ls_wdata = 32'h1; ls_bmask = 4'h1;
    for (int i = 0; i < 20; i++) begin
      mem_rvalid = (own != 0);
      mem_rdata  = 32'h100 + i;
      cyc();
    end
    chk("starve_n", grants.size(), 10);
    for (int i = 0; i < 10 && i < grants.size(); i++) chk($sformatf("order%0d", i), grants[i], pat[i]);
    {if_req, ls_req, mem_rvalid} = '0;
    cyc();

    // LSU store with unaligned address
    ls_req = 1; ls_we = 1; ls_addr = 32'h2003; ls_bmask = 4'b0011; ls_wdata = 32'h1234_5678;
    cyc();
    chk("st_addr", s_mem_addr, 32'h2000);
    chk("st_we", s_mem_we, 1);
    ls_req = 0; ls_we = 0; mem_rvalid = 1; mem_rdata = 32'hA5A5_0001;
    cyc();
    chk("st_ack", s_ls_rv, 1);
    mem_rvalid = 0;
    cyc();

    // flush one cycle after a fetch grant
    if_req = 1; if_addr = 32'h200;
    cyc();
    chk("fl_gnt", s_if_gnt, 1);
    if_req = 0; flush = 1;
    cyc();
    flush = 0; mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0;
    cyc();
    chk("fl_drop", s_if_rv, 0);
    mem_rvalid = 0; if_req = 1; if_addr = 32'h300;
    cyc();
    chk("fl_regnt", s_if_gnt, 1);
    if_req = 0; mem_rvalid = 1; mem_rdata = 32'h55;
    cyc();
    chk("fl_resp", s_if_rv, 1);
    mem_rvalid = 0;
    cyc();

    // reset in BUSY_LS then late response
    ls_req = 1; ls_addr = 32'h40;
    cyc();
    ls_req = 0;
    cyc();
    rst = 1;
    cyc();
    rst = 0; mem_rvalid = 1; mem_rdata = 32'h7777_7777;
    cyc();
    chk("lr_rv", s_ls_rv, 0);
    chk("lr_out", {s_mem_req, s_mem_addr, s_ls_rd, s_if_rd}, 0);
    mem_rvalid = 0; ls_req = 1;
    cyc();
    chk("lr_idle", s_ls_gnt, 1);
    ls_req = 0; mem_rvalid = 1;
    cyc();
    mem_rvalid = 0;

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!(if_req && last_win != 1)) begin
        if_req = $urandom_range(0, 1); if_addr = $urandom;
      end
      if (!(ls_req && last_win != 2)) begin
        ls_req = $urandom_range(0, 1); ls_we = $urandom_range(0, 1);
        ls_addr = $urandom; ls_wdata = $urandom; ls_bmask = 4'($urandom_range(0, 15));
      end
      flush = ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
      if (own != 0) begin
        if (lat == 0) mem_rvalid = 1;
        else begin mem_rvalid = 0; lat--; end
      end else begin
        mem_rvalid = ($urandom_range(0, 7) == 0);
      end
      cyc();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
